vend_dispatch: RTL

Back-end executor for the coin-vending FSM: consumes its single-cycle `x` (vend) and `y` (change) output pulses and turns them into physical actuator handshakes. Requests are queued. The product motor is driven with a req/ack handshake, and 5-unit change coins are paid out through a pulsed hopper with coin-sense confirmation. A sticky fault state is entered on any actuator timeout. The block sits between the vending FSM and the actuator pads, in the same clock domain as the FSM.

---
 rtl/vend_dispatch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vend_dispatch.sv
// Vend/change actuator executor: queues FSM x/y pulses, drives motor req/ack and hopper pulse/sense.
// Optional stats counters are enabled by defining VEND_DISPATCH_STATS_EN.
module vend_dispatch #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255,
  parameter int PULSE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       y,
  output logic       motor_req,
  input  logic       motor_ack,
  output logic       hopper_pulse,
  input  logic       hopper_sense,
  output logic       busy,
  output logic       overflow,
  output logic       fault,
  output logic [7:0] vend_count,
  output logic [7:0] change_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, VEND, CHANGE, WAIT_COIN, FAULT} state_t;

  state_t          state_q, state_d;
  logic [DEPTH-1:0] chg_q;
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [7:0]      timer_q, timer_d;
  logic [7:0]      pcnt_q, pcnt_d;
  logic            chg_cur_q, chg_cur_d;
  logic            motor_req_q, hopper_pulse_q, busy_q, overflow_q, fault_q;
  logic            pop, full, push_ok, drop;

  // Pop only from IDLE, so FAULT freezes the queue while pushes still land.
  assign pop     = (state_q == IDLE) && (cnt_q != '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign push_ok = x && (!full || pop);
  assign drop    = x && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pcnt_d    = pcnt_q;
    chg_cur_d = chg_cur_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          chg_cur_d = chg_q[rd_q];
          timer_d   = '0;
          state_d   = VEND;
        end
      end
      VEND: begin
        // Ack wins over a timer that has just reached TIMEOUT.
        if (motor_ack) begin
          if (chg_cur_q) begin
            pcnt_d  = '0;
            state_d = CHANGE;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == 8'(TIMEOUT)) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      CHANGE: begin
        if (pcnt_q == 8'(PULSE_LEN - 1)) begin
          timer_d = '0;
          state_d = WAIT_COIN;
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      WAIT_COIN: begin
        if (hopper_sense)                  state_d = IDLE;
        else if (timer_q == 8'(TIMEOUT))   state_d = FAULT;
        else                               timer_d = timer_q + 8'd1;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      chg_q          <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      cnt_q          <= '0;
      timer_q        <= '0;
      pcnt_q         <= '0;
      chg_cur_q      <= 1'b0;
      motor_req_q    <= 1'b0;
      hopper_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      pcnt_q    <= pcnt_d;
      chg_cur_q <= chg_cur_d;
      if (push_ok) begin
        chg_q[wr_q] <= y;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      // Outputs registered from next state so they track state_q exactly.
      motor_req_q    <= (state_d == VEND);
      hopper_pulse_q <= (state_d == CHANGE);
      busy_q         <= (state_d != IDLE) || (cnt_d != '0);
      overflow_q     <= overflow_q | drop;
      fault_q        <= (state_d == FAULT);
    end
  end

  assign motor_req    = motor_req_q;
  assign hopper_pulse = hopper_pulse_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;
  assign fault        = fault_q;

`ifdef VEND_DISPATCH_STATS_EN
  logic [7:0] vend_cnt_q, chg_cnt_q;
  logic       vend_inc, chg_inc;

  assign vend_inc = (state_q == VEND) && motor_ack;
  assign chg_inc  = (state_q == WAIT_COIN) && hopper_sense;

  always_ff @(posedge clk) begin
    if (rst) begin
      vend_cnt_q <= '0;
      chg_cnt_q  <= '0;
    end else begin
      if (vend_inc) vend_cnt_q <= vend_cnt_q + 8'd1;
      if (chg_inc)  chg_cnt_q  <= chg_cnt_q + 8'd1;
    end
  end

  assign vend_count   = vend_cnt_q;
  assign change_count = chg_cnt_q;
`else
  assign vend_count   = 8'd0;
  assign change_count = 8'd0;
`endif

endmodule
